vga_pixel_pipe: RTL and testbench

Parametrised, registered pixel output stage for the VGA path. It replaces the combinational colour gate between the frame source and the VGA sync module. It buffers incoming frame-store pixels in a small FIFO and pops one per active in-window pixel. It also clips to a programmable picture window, substitutes border, underflow and test-pattern colours, and presents time-aligned RGB plus `is_pic` two cycles after the sync module's address/ready.

---
 rtl/vga_pixel_pipe.sv | 223 ++++++++++++++++++++++
 tb/tb_vga_pixel_pipe.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_pixel_pipe.sv
// vga_pixel_pipe
//   Registered pixel output stage between the frame source and the VGA sync
//   module. Incoming frame-store pixels are buffered in a small FIFO and one
//   is popped per active in-window pixel. The stage clips to a picture window,
//   substitutes border, underflow and test-pattern colours, and presents RGB,
//   is_pic and Frame_Start two cycles after the sync module's address/ready.
//
//   Optional feature macro: VGA_PIPE_TPG_EN
//     defined   -> modes 1..3 (bars, solid, grid) and Solid_Color are built
//     undefined -> pattern logic is not built, the block always streams
//
// Ports
//   CLK, RST            pixel clock, asynchronous active-high reset
//   Ready_Sig           active video from the sync module
//   Column_Addr_Sig     current column
//   Row_Addr_Sig        current row
//   Pix_Valid/Pix_Data  input pixel stream, {R,G,B} MSB first
//   Pix_Ready           FIFO can accept a pixel
//   Mode                0 stream, 1 bars, 2 solid, 3 grid (latched at frame start)
//   Solid_Color         colour for mode 2
//   Clear_Err           clears Underflow_Sticky (a new underflow wins)
//   Red/Green/Blue_Sig  colour outputs
//   is_pic              output pixel lies inside the window
//   Frame_Start         one-cycle pulse aligned with the first output pixel
//   Underflow_Sticky    latched underflow flag
//   Fifo_Level          FIFO occupancy, 0..2^FIFO_AW
//
// Handshake: a pixel transfers on every rising CLK edge where Pix_Valid and
// Pix_Ready are both high. Pix_Ready depends only on FIFO fullness (and is
// low during reset), never on Pix_Valid.
module vga_pixel_pipe #(
  parameter int R_W     = 5,
  parameter int G_W     = 6,
  parameter int B_W     = 5,
  parameter int ADDR_W  = 11,
  parameter int WIN_W   = 1024,
  parameter int WIN_H   = 720,
  parameter int FIFO_AW = 4,
  parameter logic [R_W+G_W+B_W-1:0] BORDER_COLOR = '0,
  parameter logic [R_W+G_W+B_W-1:0] UF_COLOR = {{R_W{1'b1}}, {G_W{1'b0}}, {B_W{1'b1}}},
  parameter int BAR_SHIFT = 7
) (
  input  logic                       CLK,
  input  logic                       RST,
  input  logic                       Ready_Sig,
  input  logic [ADDR_W-1:0]          Column_Addr_Sig,
  input  logic [ADDR_W-1:0]          Row_Addr_Sig,
  input  logic                       Pix_Valid,
  input  logic [R_W+G_W+B_W-1:0]     Pix_Data,
  output logic                       Pix_Ready,
  input  logic [1:0]                 Mode,
  input  logic [R_W+G_W+B_W-1:0]     Solid_Color,
  input  logic                       Clear_Err,
  output logic [R_W-1:0]             Red_Sig,
  output logic [G_W-1:0]             Green_Sig,
  output logic [B_W-1:0]             Blue_Sig,
  output logic                       is_pic,
  output logic                       Frame_Start,
  output logic                       Underflow_Sticky,
  output logic [FIFO_AW:0]           Fifo_Level
);

  localparam int PIX_W = R_W + G_W + B_W;
  localparam int DEPTH = 1 << FIFO_AW;
  localparam logic [FIFO_AW:0]   DEPTH_C = DEPTH[FIFO_AW:0];
  localparam logic [FIFO_AW:0]   LVL_ONE = {{FIFO_AW{1'b0}}, 1'b1};
  localparam logic [FIFO_AW-1:0] PTR_ONE = {{(FIFO_AW-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]    WIN_W_C = WIN_W[ADDR_W:0];
  localparam logic [ADDR_W:0]    WIN_H_C = WIN_H[ADDR_W:0];

  // Stage 0: combinational decode of the sync module's outputs
  logic act, inwin, sof;
  assign act   = Ready_Sig;
  assign inwin = act && ({1'b0, Column_Addr_Sig} < WIN_W_C)
                     && ({1'b0, Row_Addr_Sig} < WIN_H_C);
  assign sof   = act && (Column_Addr_Sig == '0) && (Row_Addr_Sig == '0);

  // stream_now: this pixel belongs to a streaming frame and must pop.
  logic stream_now;

`ifdef VGA_PIPE_TPG_EN
  logic [1:0] mode_q, mode_cur;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)      mode_q <= 2'd0;
    else if (sof) mode_q <= Mode;
  end
  // The first pixel of a frame already belongs to the new frame, so it uses
  // the value being latched rather than the previous frame's mode.
  assign mode_cur   = sof ? Mode : mode_q;
  assign stream_now = (mode_cur == 2'd0);
`else
  logic unused_tpg_inputs;
  assign unused_tpg_inputs = ^{Mode, Solid_Color};
  assign stream_now = 1'b1;
`endif

  // FIFO
  logic [PIX_W-1:0]   mem [DEPTH];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FIFO_AW:0]   level;
  logic empty, full, push, pop, pop_ok, uf;

  assign empty     = (level == '0);
  assign full      = (level == DEPTH_C);
  assign Pix_Ready = !full && !RST;
  assign push      = Pix_Valid && Pix_Ready;
  assign pop       = inwin && stream_now;
  // An empty FIFO underflows even when a push lands in the same cycle:
  // there is no fall-through path from Pix_Data to the output.
  assign uf        = pop && empty;
  assign pop_ok    = pop && !empty;

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= Pix_Data;
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_ONE;
      if (pop_ok) rd_ptr <= rd_ptr + PTR_ONE;
      if (push && !pop_ok)      level <= level + LVL_ONE;
      else if (!push && pop_ok) level <= level - LVL_ONE;
    end
  end

  assign Fifo_Level = level;

  // Stage 1: registered FIFO read plus the decoded flags
  logic [PIX_W-1:0] s1_data;
  logic s1_act, s1_inwin, s1_sof, s1_uf;
`ifdef VGA_PIPE_TPG_EN
  logic [ADDR_W-1:0] s1_col;
  logic [3:0]        s1_row_lo;
  logic [1:0]        s1_mode;
  logic [PIX_W-1:0]  s1_solid;
`endif

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      s1_data  <= '0;
      s1_act   <= 1'b0;
      s1_inwin <= 1'b0;
      s1_sof   <= 1'b0;
      s1_uf    <= 1'b0;
`ifdef VGA_PIPE_TPG_EN
      s1_col    <= '0;
      s1_row_lo <= '0;
      s1_mode   <= 2'd0;
      s1_solid  <= '0;
`endif
    end else begin
      if (pop_ok) s1_data <= mem[rd_ptr];
      s1_act   <= act;
      s1_inwin <= inwin;
      s1_sof   <= sof;
      s1_uf    <= uf;
`ifdef VGA_PIPE_TPG_EN
      s1_col    <= Column_Addr_Sig;
      s1_row_lo <= Row_Addr_Sig[3:0];
      s1_mode   <= mode_cur;
      s1_solid  <= Solid_Color;
`endif
    end
  end

  // Sticky error: a new underflow wins over a simultaneous clear.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST)            Underflow_Sticky <= 1'b0;
    else if (uf)        Underflow_Sticky <= 1'b1;
    else if (Clear_Err) Underflow_Sticky <= 1'b0;
  end

  // Stage 2: colour select, highest priority first
  logic [PIX_W-1:0] color;
`ifdef VGA_PIPE_TPG_EN
  logic [2:0] bar_k;
  logic       unused_col_bits;
  assign bar_k           = s1_col[BAR_SHIFT+2:BAR_SHIFT];
  assign unused_col_bits = ^s1_col;
`endif

  always_comb begin
    color = '0;
    if (!s1_act)        color = '0;
    else if (!s1_inwin) color = BORDER_COLOR;
    else if (s1_uf)     color = UF_COLOR;
    else begin
`ifdef VGA_PIPE_TPG_EN
      case (s1_mode)
        2'd0:    color = s1_data;
        // Bar order white, yellow, cyan, green, magenta, red, blue, black.
        2'd1:    color = {{R_W{~bar_k[1]}}, {G_W{~bar_k[2]}}, {B_W{~bar_k[0]}}};
        2'd2:    color = s1_solid;
        default: color = ((s1_col[3:0] == 4'd0) || (s1_row_lo == 4'd0)) ? '1 : '0;
      endcase
`else
      color = s1_data;
`endif
    end
  end

  logic [PIX_W-1:0] rgb_q;
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      rgb_q       <= '0;
      is_pic      <= 1'b0;
      Frame_Start <= 1'b0;
    end else begin
      rgb_q       <= color;
      is_pic      <= s1_inwin;
      Frame_Start <= s1_sof;
    end
  end

  assign Red_Sig   = rgb_q[PIX_W-1 -: R_W];
  assign Green_Sig = rgb_q[B_W +: G_W];
  assign Blue_Sig  = rgb_q[B_W-1:0];

endmodule

// File: tb/tb_vga_pixel_pipe.sv
// tb_vga_pixel_pipe
//   Bench for vga_pixel_pipe with default parameters (RGB565, 1024x720
//   window, 16-deep FIFO). A frame-level model (pixel queue, per-frame mode,
//   colour table) predicts every output cycle; directed vectors add literal
//   expectations for the key cases.
module tb_vga_pixel_pipe;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // DUT signals
  logic        ready = 1'b0;
  logic [10:0] col = '0;
  logic [10:0] row = '0;
  logic        pix_valid = 1'b0;
  logic [15:0] pix_data = '0;
  logic        pix_ready;
  logic [1:0]  mode = 2'd0;
  logic [15:0] solid = '0;
  logic        clear_err = 1'b0;
  logic [4:0]  red;
  logic [5:0]  green;
  logic [4:0]  blue;
  logic        is_pic, frame_start, uf_sticky;
  logic [4:0]  level;

  vga_pixel_pipe dut (
    .CLK(clk), .RST(rst), .Ready_Sig(ready),
    .Column_Addr_Sig(col), .Row_Addr_Sig(row),
    .Pix_Valid(pix_valid), .Pix_Data(pix_data), .Pix_Ready(pix_ready),
    .Mode(mode), .Solid_Color(solid), .Clear_Err(clear_err),
    .Red_Sig(red), .Green_Sig(green), .Blue_Sig(blue),
    .is_pic(is_pic), .Frame_Start(frame_start),
    .Underflow_Sticky(uf_sticky), .Fifo_Level(level)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, got, want, $time);
    end
  endtask

  // Behavioural model
  logic [15:0] exp_q[$];
  logic [15:0] bar_tab [8];
  int          m_mode = 0;
  bit          m_sticky = 0;
  logic [15:0] cur_rgb = '0, prev_rgb = '0, m_px;
  bit          cur_pic = 0, prev_pic = 0, cur_fs = 0, prev_fs = 0;
  bit          m_act, m_win, m_sof, m_uf;
  int          m_n0;

  initial begin
    bar_tab[0] = 16'hFFFF; bar_tab[1] = 16'hFFE0; bar_tab[2] = 16'h07FF; bar_tab[3] = 16'h07E0;
    bar_tab[4] = 16'hF81F; bar_tab[5] = 16'hF800; bar_tab[6] = 16'h001F; bar_tab[7] = 16'h0000;
  end

  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
      m_mode = 0; m_sticky = 0;
      cur_rgb = '0; cur_pic = 0; cur_fs = 0;
      prev_rgb = '0; prev_pic = 0; prev_fs = 0;
    end else begin
      m_act = ready;
      m_win = m_act && (col < 1024) && (row < 720);
      m_sof = m_act && (col == 0) && (row == 0);
`ifdef VGA_PIPE_TPG_EN
      if (m_sof) m_mode = int'(mode);
`endif
      m_n0 = exp_q.size();
      m_uf = 0;
      m_px = '0;
      if (m_win && m_mode == 0) begin
        if (m_n0 == 0) m_uf = 1;
        else m_px = exp_q.pop_front();
      end
      if (pix_valid && m_n0 < 16) exp_q.push_back(pix_data);
      m_sticky = m_uf || (m_sticky && !clear_err);
      if (!m_act)      cur_rgb = 16'h0000;
      else if (!m_win) cur_rgb = 16'h0000;
      else if (m_uf)   cur_rgb = 16'hF81F;
      else if (m_mode == 0) cur_rgb = m_px;
      else if (m_mode == 1) cur_rgb = bar_tab[(int'(col) / 128) % 8];
      else if (m_mode == 2) cur_rgb = solid;
      else cur_rgb = ((int'(col) % 16 == 0) || (int'(row) % 16 == 0)) ? 16'hFFFF : 16'h0000;
      cur_pic = m_win;
      cur_fs  = m_sof;
    end
    #1;
    chk("rgb",    {16'h0, red, green, blue}, {16'h0, prev_rgb});
    chk("is_pic", {31'h0, is_pic}, {31'h0, prev_pic});
    chk("frame_start", {31'h0, frame_start}, {31'h0, prev_fs});
    chk("level",  {27'h0, level}, exp_q.size());
    chk("pix_ready", {31'h0, pix_ready}, {31'h0, (!rst && exp_q.size() < 16)});
    chk("sticky", {31'h0, uf_sticky}, {31'h0, m_sticky});
    prev_rgb = cur_rgb; prev_pic = cur_pic; prev_fs = cur_fs;
  end

  // Driver: apply one cycle's inputs on the falling edge.
  task automatic cyc(input bit rdy, input int c, input int r, input bit v, input logic [15:0] d);
    @(negedge clk);
    ready = rdy; col = c[10:0]; row = r[10:0]; pix_valid = v; pix_data = d;
  endtask

  task automatic idle();
    cyc(0, 0, 0, 0, 16'h0);
  endtask

  // Result of the cycle driven two cyc() calls ago is visible now.
  task automatic chk_rgb(input string name, input logic [15:0] want);
    chk(name, {16'h0, red, green, blue}, {16'h0, want});
  endtask

  initial begin
    // Reset
    repeat (2) @(negedge clk);
    chk("rst_ready", {31'h0, pix_ready}, 32'h0);
    chk_rgb("rst_rgb", 16'h0);
    rst = 1'b0;

    // Stream three pixels
    cyc(0, 0, 0, 1, 16'hF800);
    cyc(0, 0, 0, 1, 16'h07E0);
    cyc(0, 0, 0, 1, 16'h001F);
    cyc(1, 0, 5, 0, 16'h0);
    cyc(1, 1, 5, 0, 16'h0);
    cyc(1, 2, 5, 0, 16'h0);
    chk("stream_r", {27'h0, red}, 32'd31);
    chk("stream_g0", {26'h0, green}, 32'd0);
    idle();
    chk("stream_g", {26'h0, green}, 32'd63);
    chk("stream_pic", {31'h0, is_pic}, 32'd1);
    idle();
    chk("stream_b", {27'h0, blue}, 32'd31);
    chk_rgb("stream_px2", 16'h001F);
    chk("stream_lvl", {27'h0, level}, 32'd0);

    // Underflow, sticky hold and clear
    cyc(1, 10, 5, 0, 16'h0);
    idle();
    idle();
    chk_rgb("uf_rgb", 16'hF81F);
    chk("uf_sticky", {31'h0, uf_sticky}, 32'd1);
    repeat (3) idle();
    chk("uf_hold", {31'h0, uf_sticky}, 32'd1);
    clear_err = 1'b1;
    idle();
    clear_err = 1'b0;
    idle();
    chk("uf_clear", {31'h0, uf_sticky}, 32'd0);
    cyc(1, 11, 5, 0, 16'h0);
    clear_err = 1'b1;
    idle();
    clear_err = 1'b0;
    idle();
    chk("uf_set_wins", {31'h0, uf_sticky}, 32'd1);
    cyc(1, 12, 5, 1, 16'hABCD);
    idle();
    idle();
    chk_rgb("uf_pushpop_rgb", 16'hF81F);
    chk("uf_pushpop_lvl", {27'h0, level}, 32'd1);
    cyc(1, 13, 5, 0, 16'h0);
    idle();
    idle();
    chk_rgb("uf_after", 16'hABCD);
    clear_err = 1'b1;
    idle();
    clear_err = 1'b0;

    // Full FIFO
    for (int i = 0; i < 16; i++) cyc(0, 0, 0, 1, 16'h0101 + 16'(i * 16'h0203));
    cyc(0, 0, 0, 1, 16'hDEAD);
    chk("full_ready", {31'h0, pix_ready}, 32'd0);
    chk("full_lvl", {27'h0, level}, 32'd16);
    idle();
    chk("full_17th", {27'h0, level}, 32'd16);
    for (int i = 0; i < 16; i++) begin
      cyc(1, 20 + i, 7, 0, 16'h0);
      if (i == 2) chk_rgb("drain_first", 16'h0101);
    end
    idle();
    idle();
    chk("drain_lvl", {27'h0, level}, 32'd0);

    // Window clip and blanking
    cyc(0, 0, 0, 1, 16'h5555);
    cyc(1, 1030, 100, 0, 16'h0);
    cyc(1, 5, 720, 0, 16'h0);
    cyc(0, 5, 5, 0, 16'h0);
    chk_rgb("clip_col", 16'h0);
    chk("clip_pic", {31'h0, is_pic}, 32'd0);
    chk("clip_lvl", {27'h0, level}, 32'd1);
    cyc(1, 40, 9, 0, 16'h0);
    chk_rgb("clip_row", 16'h0);
    idle();
    chk_rgb("blank", 16'h0);
    idle();
    chk_rgb("clip_drain", 16'h5555);

    // Mid-frame reset
    cyc(0, 0, 0, 1, 16'h1111);
    cyc(1, 30, 9, 1, 16'h2222);
    cyc(1, 31, 9, 1, 16'h3333);
    rst = 1'b1;
    idle();
    chk("mrst_ready", {31'h0, pix_ready}, 32'd0);
    chk_rgb("mrst_rgb", 16'h0);
    rst = 1'b0;
    chk("mrst_lvl", {27'h0, level}, 32'd0);
    cyc(1, 32, 9, 0, 16'h0);
    idle();
    chk_rgb("mrst_first_pre", 16'h0);
    idle();
    chk_rgb("mrst_first", 16'hF81F);

    // Frame start pulse
    cyc(0, 0, 0, 1, 16'h4444);
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 1, 0, 0, 16'h0);
    idle();
    chk("fs_pulse", {31'h0, frame_start}, 32'd1);
    idle();
    chk("fs_once", {31'h0, frame_start}, 32'd0);

`ifdef VGA_PIPE_TPG_EN
    // Mode latch: change mid-frame, takes effect at the next frame
    cyc(0, 0, 0, 1, 16'h1234);
    mode = 2'd1;
    cyc(1, 5, 10, 0, 16'h0);
    idle();
    idle();
    chk_rgb("tpg_latch_stream", 16'h1234);
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 300, 0, 0, 16'h0);
    cyc(1, 128, 0, 0, 16'h0);
    chk_rgb("bars_white", 16'hFFFF);
    chk("bars_fs", {31'h0, frame_start}, 32'd1);
    idle();
    chk_rgb("bars_cyan", 16'h07FF);
    idle();
    chk_rgb("bars_yellow", 16'hFFE0);
    chk("bars_lvl", {27'h0, level}, 32'd0);
    mode = 2'd2;
    solid = 16'h1357;
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 50, 3, 0, 16'h0);
    idle();
    idle();
    chk_rgb("solid", 16'h1357);
    mode = 2'd3;
    cyc(1, 0, 0, 0, 16'h0);
    cyc(1, 16, 3, 0, 16'h0);
    cyc(1, 17, 3, 0, 16'h0);
    idle();
    chk_rgb("grid_line", 16'hFFFF);
    idle();
    chk_rgb("grid_black", 16'h0000);
    mode = 2'd0;
    cyc(1, 0, 0, 0, 16'h0);
    idle();
`endif

    // Mixed sweep over a few lines; checked by the model every cycle
    for (int r = 0; r < 3; r++) begin
      for (int c = 0; c < 40; c++)
        cyc(c < 30, c * 40, r * 300, (c % 3) != 0, 16'(r * 1000 + c * 77));
    end
    repeat (4) idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
